// File: rtl/key_matrix_scanner_pkg.sv
// Shared keypad matrix definitions: geometry, scanner states and the row decode
// helper also used by the key-value decoder.
package key_pkg;

    localparam int NUM_ROW   = 6;
    localparam int NUM_COL   = 5;
    localparam int COL_IDX_W = 3;
    localparam int CODE_W    = 6;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD
    } state_e;

    // Returns 1..NUM_ROW for exactly one low bit; 0 for no key or a ghosting pattern.
    function automatic logic [2:0] onehot_low_to_code(input logic [NUM_ROW-1:0] row);
        logic [2:0]  code;
        int unsigned lows;
        code = 3'd0;
        lows = 0;
        for (int i = 0; i < NUM_ROW; i++) begin
            if (!row[i]) begin
                lows++;
                code = 3'(i + 1);
            end
        end
        return (lows == 1) ? code : 3'd0;
    endfunction

endpackage

// File: rtl/key_matrix_scanner_if.sv
// Keypad pins plus the key-event outputs seen by the key-handling logic.
interface key_matrix_scanner_if;
    import key_pkg::*;

    logic [NUM_ROW-1:0] ROW;
    logic [NUM_COL-1:0] COLUM;
    logic [CODE_W-1:0]  KEY_VALUE;
    logic               KEY_VALID;
    logic               KEY_HELD;
    logic               KEY_RELEASE;

    modport master (
        input  ROW,
        output COLUM,
        output KEY_VALUE,
        output KEY_VALID,
        output KEY_HELD,
        output KEY_RELEASE
    );

    modport slave (
        output ROW,
        input  COLUM,
        input  KEY_VALUE,
        input  KEY_VALID,
        input  KEY_HELD,
        input  KEY_RELEASE
    );

endinterface

// File: rtl/key_matrix_scanner_row_sync.sv
// Two-flop synchronizer for the asynchronous active-low keypad rows.
module key_row_sync
    import key_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_ROW-1:0] row_i,
    output logic [NUM_ROW-1:0] row_o
);

    logic [NUM_ROW-1:0] meta_q;
    logic [NUM_ROW-1:0] sync_q;

    // Reset to all-ones so a reset reads as "no key pressed".
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= row_i;
            sync_q <= meta_q;
        end
    end

    assign row_o = sync_q;

endmodule

// File: rtl/key_matrix_scanner.sv
// Column-walking keypad scanner with press/release debouncing and single-key tracking.
module key_matrix_scanner
    import key_pkg::*;
#(
    parameter int SCAN_DIV     = 4,
    parameter int DEBOUNCE_CNT = 3,
    parameter int CNT_W        = 8
) (
    input  logic                 CLK_LOW,
    input  logic                 RST,
    key_matrix_scanner_if.master kbd
);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_TARGET = CNT_W'(DEBOUNCE_CNT);

    logic [NUM_ROW-1:0]   rowSync;
    logic [2:0]           rowCode;
    logic [CODE_W-1:0]    sampleCode;
    logic                 hit;
    logic                 scanActive;
    logic                 samplePt;
    logic                 advance;
    logic [CNT_W-1:0]     debNext;
    logic [CNT_W-1:0]     relNext;

    state_e               state_q,     state_d;
    logic [COL_IDX_W-1:0] colIdx_q,    colIdx_d;
    logic [CNT_W-1:0]     dwell_q,     dwell_d;
    logic [CNT_W-1:0]     debCnt_q,    debCnt_d;
    logic [CNT_W-1:0]     relCnt_q,    relCnt_d;
    logic [CODE_W-1:0]    cand_q,      cand_d;
    logic [CODE_W-1:0]    keyValue_q,  keyValue_d;
    logic                 keyValid_q,  keyValid_d;
    logic                 keyHeld_q,   keyHeld_d;
    logic                 keyRelease_q, keyRelease_d;
    logic [NUM_COL-1:0]   colum_q,     colum_d;

    key_row_sync u_row_sync (
        .clk_i (CLK_LOW),
        .rst_i (RST),
        .row_i (kbd.ROW),
        .row_o (rowSync)
    );

    // The dwell counter only runs once a column is actually driven, so the
    // first column after reset gets its full SCAN_DIV cycles.
    assign scanActive = (colum_q != '1);
    assign samplePt   = scanActive && (dwell_q == DWELL_LAST);
    assign rowCode    = onehot_low_to_code(rowSync);
    assign hit        = (rowCode != 3'd0);
    assign sampleCode = {colIdx_q + COL_IDX_W'(1), rowCode};
    assign debNext    = debCnt_q + CNT_W'(1);
    assign relNext    = relCnt_q + CNT_W'(1);

    always_comb begin
        state_d      = state_q;
        colIdx_d     = colIdx_q;
        dwell_d      = dwell_q;
        debCnt_d     = debCnt_q;
        relCnt_d     = relCnt_q;
        cand_d       = cand_q;
        keyValue_d   = keyValue_q;
        keyValid_d   = 1'b0;
        keyHeld_d    = keyHeld_q;
        keyRelease_d = 1'b0;
        advance      = 1'b0;

        if (scanActive) begin
            dwell_d = samplePt ? '0 : dwell_q + CNT_W'(1);
        end

        if (samplePt) begin
            unique case (state_q)
                SCAN: begin
                    if (hit) begin
                        cand_d   = sampleCode;
                        debCnt_d = CNT_W'(1);
                        if (DEBOUNCE_CNT == 1) begin
                            keyValue_d = sampleCode;
                            keyValid_d = 1'b1;
                            keyHeld_d  = 1'b1;
                            relCnt_d   = '0;
                            state_d    = HELD;
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end else begin
                        advance = 1'b1;
                    end
                end

                DEBOUNCE: begin
                    if (hit && (sampleCode == cand_q)) begin
                        debCnt_d = debNext;
                        if (debNext == DEB_TARGET) begin
                            keyValue_d = cand_q;
                            keyValid_d = 1'b1;
                            keyHeld_d  = 1'b1;
                            relCnt_d   = '0;
                            state_d    = HELD;
                        end
                    end else begin
                        advance = 1'b1;
                        state_d = SCAN;
                    end
                end

                HELD: begin
                    // A different key on this column counts as the tracked key being up.
                    if (hit && (sampleCode == keyValue_q)) begin
                        relCnt_d = '0;
                    end else begin
                        relCnt_d = relNext;
                        if (relNext == DEB_TARGET) begin
                            keyHeld_d    = 1'b0;
                            keyRelease_d = 1'b1;
                            advance      = 1'b1;
                            state_d      = SCAN;
                        end
                    end
                end

                default: begin
                    advance = 1'b1;
                    state_d = SCAN;
                end
            endcase
        end

        if (advance) begin
            colIdx_d = (colIdx_q == COL_IDX_W'(NUM_COL - 1)) ? '0 : colIdx_q + COL_IDX_W'(1);
        end

        colum_d = ~(NUM_COL'(1) << colIdx_d);
    end

    always_ff @(posedge CLK_LOW) begin
        if (RST) begin
            state_q      <= SCAN;
            colIdx_q     <= '0;
            dwell_q      <= '0;
            debCnt_q     <= '0;
            relCnt_q     <= '0;
            cand_q       <= '0;
            keyValue_q   <= '0;
            keyValid_q   <= 1'b0;
            keyHeld_q    <= 1'b0;
            keyRelease_q <= 1'b0;
            colum_q      <= '1;
        end else begin
            state_q      <= state_d;
            colIdx_q     <= colIdx_d;
            dwell_q      <= dwell_d;
            debCnt_q     <= debCnt_d;
            relCnt_q     <= relCnt_d;
            cand_q       <= cand_d;
            keyValue_q   <= keyValue_d;
            keyValid_q   <= keyValid_d;
            keyHeld_q    <= keyHeld_d;
            keyRelease_q <= keyRelease_d;
            colum_q      <= colum_d;
        end
    end

    assign kbd.COLUM       = colum_q;
    assign kbd.KEY_VALUE   = keyValue_q;
    assign kbd.KEY_VALID   = keyValid_q;
    assign kbd.KEY_HELD    = keyHeld_q;
    assign kbd.KEY_RELEASE = keyRelease_q;

endmodule

// File: tb/tb_key_matrix_scanner.sv
// Scoreboard bench for key_matrix_scanner: a keypad matrix model drives ROW from COLUM,
// expected press/release events are queued by the stimulus and popped by a monitor.
module tb_key_matrix_scanner;
    import key_pkg::*;

    typedef struct packed {
        logic       isRelease;
        logic [5:0] value;
    } sbEntry_t;

    logic CLK_LOW;
    logic RST;
    int   compareCount;
    int   mismatchCount;
    logic [5:0] pressMask [NUM_COL];
    logic [5:0] rowDrive;
    sbEntry_t   expectQ [$];
    sbEntry_t   popped;

    key_matrix_scanner_if kbd ();

    key_matrix_scanner #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (3),
        .CNT_W        (8)
    ) dut (
        .CLK_LOW (CLK_LOW),
        .RST     (RST),
        .kbd     (kbd.master)
    );

    initial CLK_LOW = 1'b0;
    always #5 CLK_LOW = ~CLK_LOW;

    // Matrix model: a pressed key shorts its row low while its column is driven low.
    always_comb begin
        rowDrive = '1;
        for (int c = 0; c < NUM_COL; c++) begin
            if (!kbd.COLUM[c]) rowDrive = rowDrive & ~pressMask[c];
        end
    end
    assign kbd.ROW = rowDrive;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic pushExpected(input logic isRelease, input logic [5:0] value);
        sbEntry_t e;
        e.isRelease = isRelease;
        e.value     = value;
        expectQ.push_back(e);
    endtask

    // Monitor: every KEY_VALID or KEY_RELEASE pulse must match the oldest queued event.
    always @(negedge CLK_LOW) begin
        if (kbd.KEY_VALID || kbd.KEY_RELEASE) begin
            compareCount++;
            if (kbd.KEY_VALID && kbd.KEY_RELEASE) begin
                mismatchCount++;
                $display("[TB] FAIL event_overlap: got VALID=1 RELEASE=1, expected only one");
            end else if (expectQ.size() == 0) begin
                mismatchCount++;
                $display("[TB] FAIL event_unexpected: got VALID=%0b RELEASE=%0b value=%0d, expected no event",
                         kbd.KEY_VALID, kbd.KEY_RELEASE, kbd.KEY_VALUE);
            end else begin
                popped = expectQ.pop_front();
                if (popped.isRelease !== kbd.KEY_RELEASE || popped.value !== kbd.KEY_VALUE ||
                    kbd.KEY_HELD !== !popped.isRelease) begin
                    mismatchCount++;
                    $display("[TB] FAIL event: got release=%0b value=%0d held=%0b, expected release=%0b value=%0d held=%0b",
                             kbd.KEY_RELEASE, kbd.KEY_VALUE, kbd.KEY_HELD,
                             popped.isRelease, popped.value, !popped.isRelease);
                end
            end
        end
    end

    task automatic applyReset();
        RST = 1'b1;
        @(negedge CLK_LOW);
        @(negedge CLK_LOW);
        checkOutput("reset_colum",   32'(kbd.COLUM),       32'h1F);
        checkOutput("reset_value",   32'(kbd.KEY_VALUE),   32'h0);
        checkOutput("reset_valid",   32'(kbd.KEY_VALID),   32'h0);
        checkOutput("reset_held",    32'(kbd.KEY_HELD),    32'h0);
        checkOutput("reset_release", 32'(kbd.KEY_RELEASE), 32'h0);
        RST = 1'b0;
    endtask

    task automatic waitColumn(input logic [4:0] target, input string name);
        bit found = 0;
        for (int n = 0; n < 60 && !found; n++) begin
            @(negedge CLK_LOW);
            if (kbd.COLUM == target) found = 1;
        end
        checkOutput(name, 32'(found), 32'h1);
    endtask

    task automatic waitHeld(input logic level, input string name);
        bit found = 0;
        for (int n = 0; n < 80 && !found; n++) begin
            @(negedge CLK_LOW);
            if (kbd.KEY_HELD == level) found = 1;
        end
        checkOutput(name, 32'(found), 32'h1);
    endtask

    task automatic applyStimulus();
        logic [4:0] expCol;

        // Idle scan: each column low for 4 cycles, rotating 0..4.
        applyReset();
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK_LOW);
            expCol = ~(5'b00001 << ((k / 4) % 5));
            checkOutput("idle_colum", 32'(kbd.COLUM), 32'(expCol));
        end
        checkOutput("idle_value", 32'(kbd.KEY_VALUE), 32'h0);
        checkOutput("idle_held",  32'(kbd.KEY_HELD),  32'h0);

        // Press row3/col2: first sample 3 cycles into the column, held 9 cycles after that.
        applyReset();
        pressMask[1] = 6'b000100;
        pushExpected(1'b0, 6'd19);
        waitColumn(5'b11101, "press_col2_reached");
        repeat (11) @(negedge CLK_LOW);
        checkOutput("press_held_early", 32'(kbd.KEY_HELD), 32'h0);
        checkOutput("press_colum_hold", 32'(kbd.COLUM),    32'h1D);
        @(negedge CLK_LOW);
        checkOutput("press_held_latency", 32'(kbd.KEY_HELD),  32'h1);
        checkOutput("press_value",        32'(kbd.KEY_VALUE), 32'd19);
        repeat (20) @(negedge CLK_LOW);
        checkOutput("press_colum_frozen", 32'(kbd.COLUM),    32'h1D);
        checkOutput("press_still_held",   32'(kbd.KEY_HELD), 32'h1);

        // Release: three empty samples at +3, +7, +11, pulse on +12.
        pressMask[1] = 6'b000000;
        pushExpected(1'b1, 6'd19);
        repeat (11) @(negedge CLK_LOW);
        checkOutput("release_held_early", 32'(kbd.KEY_HELD),    32'h1);
        checkOutput("release_not_yet",    32'(kbd.KEY_RELEASE), 32'h0);
        @(negedge CLK_LOW);
        checkOutput("release_pulse", 32'(kbd.KEY_RELEASE), 32'h1);
        checkOutput("release_held",  32'(kbd.KEY_HELD),    32'h0);
        checkOutput("release_value", 32'(kbd.KEY_VALUE),   32'd19);
        checkOutput("release_colum", 32'(kbd.COLUM),       32'h1B);

        // Bounce: key seen by exactly one sample, column held one extra dwell then moves on.
        waitColumn(5'b11101, "bounce_col2_reached");
        pressMask[1] = 6'b000100;
        repeat (4) @(negedge CLK_LOW);
        checkOutput("bounce_col_held", 32'(kbd.COLUM), 32'h1D);
        pressMask[1] = 6'b000000;
        repeat (4) @(negedge CLK_LOW);
        checkOutput("bounce_resume", 32'(kbd.COLUM),     32'h1B);
        checkOutput("bounce_value",  32'(kbd.KEY_VALUE), 32'd19);
        checkOutput("bounce_held",   32'(kbd.KEY_HELD),  32'h0);

        // Ghost: rows 1 and 2 on col1 are a multi hit and must never stall the scan.
        pressMask[0] = 6'b000011;
        waitColumn(5'b11110, "multi_col1_reached");
        for (int j = 0; j < 15; j++) begin
            expCol = ~(5'b00001 << (j % 5));
            checkOutput("multi_colum", 32'(kbd.COLUM), 32'(expCol));
            repeat (4) @(negedge CLK_LOW);
        end
        checkOutput("multi_held", 32'(kbd.KEY_HELD), 32'h0);
        pressMask[0] = 6'b000000;

        // Reset while held, then the still-pressed key is re-accepted.
        applyReset();
        pressMask[1] = 6'b000100;
        pushExpected(1'b0, 6'd19);
        waitHeld(1'b1, "rst_first_accept");
        RST = 1'b1;
        @(negedge CLK_LOW);
        checkOutput("rst_mid_colum", 32'(kbd.COLUM),     32'h1F);
        checkOutput("rst_mid_held",  32'(kbd.KEY_HELD),  32'h0);
        checkOutput("rst_mid_value", 32'(kbd.KEY_VALUE), 32'h0);
        RST = 1'b0;
        pushExpected(1'b0, 6'd19);
        waitHeld(1'b1, "rst_reaccept");
        checkOutput("rst_reaccept_value", 32'(kbd.KEY_VALUE), 32'd19);
        pressMask[1] = 6'b000000;
        pushExpected(1'b1, 6'd19);
        waitHeld(1'b0, "rst_final_release");
        repeat (30) @(negedge CLK_LOW);
        checkOutput("scoreboard_drained", 32'(expectQ.size()), 32'h0);
    endtask

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        RST           = 1'b1;
        for (int c = 0; c < NUM_COL; c++) pressMask[c] = 6'b000000;
        applyStimulus();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

    initial begin
        repeat (20000) @(posedge CLK_LOW);
        $display("[TB] FAIL watchdog: got no completion, expected finish within 20000 cycles");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/key_matrix_scanner.md
Name: key_matrix_scanner

Overview:
Drives the keypad column lines and reads the row lines. It is the scanning side of the keypad matrix, opposite the existing key-value decoder.
- Walks one active-low column at a time and samples the synchronized rows.
- Debounces a single pressed key, then reports it with the same 6-bit code as the decoder: {col[2:0], row[2:0]}, both 1-based.
- Also reports hold and release.
- Sits between the front-panel keypad pins and the key-handling logic, on the slow clock domain.

Parameters:
SCAN_DIV, 4, clocks each column is driven before ROW is sampled (minimum 4: covers the 2-FF sync plus settling)
DEBOUNCE_CNT, 3, consecutive matching samples required for both press and release (minimum 1)
CNT_W, 8, width of the dwell and debounce counters (must hold SCAN_DIV-1 and DEBOUNCE_CNT)

Ports:
CLK_LOW  in  1  slow system clock; all logic on its rising edge
RST  in  1  synchronous reset, active-high
ROW  in  6  keypad rows, active-low, asynchronous
COLUM  out  5  column drive, active-low, one-hot-low while scanning
KEY_VALUE  out  6  {col code, row code} of the last accepted key; holds its value after release
KEY_VALID  out  1  one-cycle pulse when a press is accepted
KEY_HELD  out  1  high from press acceptance until release acceptance
KEY_RELEASE  out  1  one-cycle pulse when a release is accepted

Behaviour:
Interface:
- One clock, CLK_LOW. Reset is RST: synchronous, active-high.
- Reset values: COLUM=5'b11111, KEY_VALUE=6'd0, KEY_VALID=0, KEY_HELD=0, KEY_RELEASE=0. All counters and sync flops clear; state=SCAN; column index=0.
- First clock after RST deasserts: COLUM=5'b11110.
- RST asserted in any state forces reset values on the next edge, including mid-debounce and mid-hold.

Input sampling:
- ROW passes through a 2-FF synchronizer before use.
- Dwell counter runs 0..SCAN_DIV-1 and restarts on every column change.
- The sample point is the cycle where dwell==SCAN_DIV-1; the synchronized ROW is evaluated there.
- Sample classification:
  - exactly one ROW bit low → "hit", row code 1..6 (bit0→1 … bit5→6)
  - all bits high → "empty"
  - two or more bits low → "multi", treated exactly as empty (ghost rejection)
- Column code = column index + 1.

State machine:
- SCAN:
  - At each sample point, if empty or multi: advance the index (4 wraps to 0) and drive the next column from the next cycle.
  - If hit: latch the candidate code, set deb_cnt=1, keep the current column. If DEBOUNCE_CNT==1, accept immediately as in DEBOUNCE; otherwise go to DEBOUNCE.
- DEBOUNCE (column held):
  - At each sample point, if the code equals the candidate: deb_cnt+1.
  - When deb_cnt reaches DEBOUNCE_CNT: KEY_VALUE<=candidate, KEY_VALID=1 for one cycle, KEY_HELD=1, go to HELD.
  - On a mismatch or empty sample: discard the candidate, advance the column, go to SCAN.
- HELD (column held):
  - At each sample point, empty or multi increments rel_cnt; a hit matching KEY_VALUE clears rel_cnt.
  - A hit with a different row counts as empty. Only one key is tracked at a time.
  - When rel_cnt reaches DEBOUNCE_CNT: KEY_HELD=0, KEY_RELEASE=1 for one cycle, advance the column, go to SCAN.

Timing:
- KEY_VALID and KEY_HELD rise on the edge after the accepting sample.
- KEY_VALID and KEY_RELEASE are never high in the same cycle.
- Press latency from the first hit sample is (DEBOUNCE_CNT-1)*SCAN_DIV+1 cycles.

Decomposition:
- Package key_pkg:
  - NUM_ROW=6, NUM_COL=5
  - state enum {SCAN, DEBOUNCE, HELD}
  - function onehot_low_to_code (returns 0 for empty or multi); the existing decoder shares this function
- Sub-module key_row_sync: 6-bit 2-FF synchronizer, with reset to all-ones.

Test Plan:
All scenarios use SCAN_DIV=4, DEBOUNCE_CNT=3. A matrix model pulls ROW[r] low while COLUM[c]==0 and key (r,c) is pressed.
1. No keys, 40 cycles after reset → COLUM cycles 11110,11101,11011,10111,01111,11110, each for 4 cycles; KEY_VALID and KEY_HELD stay 0; KEY_VALUE=0.
2. Press row3/col2 and hold → COLUM freezes at 11101; exactly one KEY_VALID pulse; KEY_VALUE=6'd19 (010_011); KEY_HELD=1 exactly 9 cycles after the first hit sample.
3. Press row3/col2 for one sample only (bounce) → no KEY_VALID; KEY_VALUE unchanged; scan resumes at 11011.
4. row1 and row2 both pressed on col1 → multi on every pass; no KEY_VALID ever; scanning never stalls.
5. Continue from scenario 2 and release → after 3 empty samples: one KEY_RELEASE pulse; KEY_HELD=0; KEY_VALUE still 19; next column 11011.
6. RST high for 1 cycle while HELD → next cycle COLUM=11111, KEY_HELD=0, KEY_VALUE=0. After release of RST, key still held → re-accepted with a fresh KEY_VALID and KEY_VALUE=19.
